// File: rtl/control_unit_pkg.sv
// Shared types and constants for the hard-wired CPU control unit:
// state encoding, opcode map, ALU select codes and IR field positions.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_RR,
        CLS_IMM,
        CLS_MULDIV,
        CLS_UNARY,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } opclass_t;

    localparam logic [4:0] OP_ADD  = 5'h03;
    localparam logic [4:0] OP_SUB  = 5'h04;
    localparam logic [4:0] OP_SHR  = 5'h05;
    localparam logic [4:0] OP_SHL  = 5'h06;
    localparam logic [4:0] OP_ROR  = 5'h07;
    localparam logic [4:0] OP_ROL  = 5'h08;
    localparam logic [4:0] OP_AND  = 5'h09;
    localparam logic [4:0] OP_OR   = 5'h0A;
    localparam logic [4:0] OP_SHRA = 5'h0B;
    localparam logic [4:0] OP_ADDI = 5'h0C;
    localparam logic [4:0] OP_ANDI = 5'h0D;
    localparam logic [4:0] OP_ORI  = 5'h0E;
    localparam logic [4:0] OP_MUL  = 5'h0F;
    localparam logic [4:0] OP_DIV  = 5'h10;
    localparam logic [4:0] OP_NEG  = 5'h11;
    localparam logic [4:0] OP_NOT  = 5'h12;
    localparam logic [4:0] OP_NOP  = 5'h14;
    localparam logic [4:0] OP_HALT = 5'h15;

    localparam logic [4:0] ALU_ADD = 5'h03;
    localparam logic [4:0] ALU_AND = 5'h09;
    localparam logic [4:0] ALU_OR  = 5'h0A;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    function automatic opclass_t decodeClass(input logic [4:0] op);
        opclass_t cls;
        cls = CLS_ILLEGAL;
        if (op >= OP_ADD && op <= OP_SHRA)       cls = CLS_RR;
        else if (op >= OP_ADDI && op <= OP_ORI)  cls = CLS_IMM;
        else if (op == OP_MUL || op == OP_DIV)   cls = CLS_MULDIV;
        else if (op == OP_NEG || op == OP_NOT)   cls = CLS_UNARY;
        else if (op == OP_NOP)                   cls = CLS_NOP;
        else if (op == OP_HALT)                  cls = CLS_HALT;
        return cls;
    endfunction

    // Immediate forms reuse the reg-reg ALU operation they correspond to.
    function automatic logic [4:0] immAluSel(input logic [4:0] op);
        logic [4:0] sel;
        sel = ALU_ADD;
        if (op == OP_ANDI)     sel = ALU_AND;
        else if (op == OP_ORI) sel = ALU_OR;
        return sel;
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control bus between the control unit (master) and the datapath (slave):
// decoded strobes/selects out, IR and memory handshake in.
interface control_unit_if #(
    parameter int NUM_REGS = 16
);
    logic                Start;
    logic [31:0]         IR;
    logic                Mem_ready;

    logic                PCout, Zlowout, Zhighout, MDRout, Cout;
    logic                MARin, MDRin, IRin, PCin, Yin, Zin, HIin, LOin;
    logic                IncPC, Read;
    logic [NUM_REGS-1:0] Rin, Rout;
    logic [4:0]          ALU_Sel;
    logic                Busy, Halted, Err;

    modport master (
        input  Start, IR, Mem_ready,
        output PCout, Zlowout, Zhighout, MDRout, Cout,
        output MARin, MDRin, IRin, PCin, Yin, Zin, HIin, LOin,
        output IncPC, Read, Rin, Rout, ALU_Sel, Busy, Halted, Err
    );

    modport slave (
        output Start, IR, Mem_ready,
        input  PCout, Zlowout, Zhighout, MDRout, Cout,
        input  MARin, MDRin, IRin, PCin, Yin, Zin, HIin, LOin,
        input  IncPC, Read, Rin, Rout, ALU_Sel, Busy, Halted, Err
    );
endinterface

// File: rtl/control_unit_reg_select.sv
// Converts a 4-bit register index into a one-hot register strobe vector.
module reg_select #(
    parameter int NUM_REGS = 16
) (
    input  logic [3:0]          idx_i,
    input  logic                en_i,
    output logic [NUM_REGS-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i && (32'(idx_i) < NUM_REGS)) begin
            onehot_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/control_unit.sv
// Hard-wired Moore control unit: sequences fetch (T0-T2) and execute (T3-T6)
// of the shared-bus datapath from the present state and the IR fields.
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic          Clock,
    input  logic          Reset_n,
    control_unit_if.master bus
);

    state_t   state_q, state_d;
    logic     t1First_q, t1First_d;

    logic [4:0] opcode;
    logic [3:0] raIdx, rbIdx, rcIdx;
    opclass_t   opClass;

    logic       rinEn, routEn;
    logic [3:0] rinIdx, routIdx;

    assign opcode  = bus.IR[OPC_MSB:OPC_LSB];
    assign raIdx   = bus.IR[RA_MSB:RA_LSB];
    assign rbIdx   = bus.IR[RB_MSB:RB_LSB];
    assign rcIdx   = bus.IR[RC_MSB:RC_LSB];
    assign opClass = decodeClass(opcode);

    always_comb begin
        state_d   = state_q;
        t1First_d = 1'b0;
        case (state_q)
            S_IDLE: if (bus.Start) state_d = S_T0;
            S_T0: begin
                state_d   = S_T1;
                t1First_d = 1'b1;
            end
            S_T1: if (bus.Mem_ready) state_d = S_T2;
            S_T2: state_d = S_T3;
            S_T3: begin
                case (opClass)
                    CLS_NOP, CLS_ILLEGAL: state_d = S_T0;
                    CLS_HALT:             state_d = S_HALT;
                    default:              state_d = S_T4;
                endcase
            end
            S_T4: state_d = (opClass == CLS_UNARY)  ? S_T0 : S_T5;
            S_T5: state_d = (opClass == CLS_MULDIV) ? S_T6 : S_T0;
            S_T6: state_d = S_T0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            t1First_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            t1First_q <= t1First_d;
        end
    end

    // IDLE drives ALU_Sel to 0 so that reset leaves every output low.
    always_comb begin
        bus.PCout    = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.Zhighout = 1'b0;
        bus.MDRout   = 1'b0;
        bus.Cout     = 1'b0;
        bus.MARin    = 1'b0;
        bus.MDRin    = 1'b0;
        bus.IRin     = 1'b0;
        bus.PCin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.Zin      = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        bus.IncPC    = 1'b0;
        bus.Read     = 1'b0;
        bus.ALU_Sel  = ALU_ADD;
        bus.Busy     = (state_q != S_IDLE) && (state_q != S_HALT);
        bus.Halted   = (state_q == S_HALT);
        bus.Err      = 1'b0;
        rinEn        = 1'b0;
        routEn       = 1'b0;
        rinIdx       = raIdx;
        routIdx      = rbIdx;
        case (state_q)
            S_IDLE: bus.ALU_Sel = 5'h00;
            S_T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.Zin   = 1'b1;
            end
            S_T1: begin
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
                bus.Zlowout = t1First_q;
                bus.PCin    = t1First_q;
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            S_T3: begin
                case (opClass)
                    CLS_RR, CLS_IMM: begin
                        routEn  = 1'b1;
                        bus.Yin = 1'b1;
                    end
                    CLS_MULDIV: begin
                        routEn  = 1'b1;
                        routIdx = raIdx;
                        bus.Yin = 1'b1;
                    end
                    CLS_UNARY: begin
                        routEn      = 1'b1;
                        bus.Zin     = 1'b1;
                        bus.ALU_Sel = opcode;
                    end
                    CLS_ILLEGAL: bus.Err = 1'b1;
                    default: ;
                endcase
            end
            S_T4: begin
                case (opClass)
                    CLS_RR: begin
                        routEn      = 1'b1;
                        routIdx     = rcIdx;
                        bus.Zin     = 1'b1;
                        bus.ALU_Sel = opcode;
                    end
                    CLS_IMM: begin
                        bus.Cout    = 1'b1;
                        bus.Zin     = 1'b1;
                        bus.ALU_Sel = immAluSel(opcode);
                    end
                    CLS_MULDIV: begin
                        routEn      = 1'b1;
                        bus.Zin     = 1'b1;
                        bus.ALU_Sel = opcode;
                    end
                    CLS_UNARY: begin
                        bus.Zlowout = 1'b1;
                        rinEn       = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (opClass)
                    CLS_RR, CLS_IMM: begin
                        bus.Zlowout = 1'b1;
                        rinEn       = 1'b1;
                    end
                    CLS_MULDIV: begin
                        bus.Zlowout = 1'b1;
                        bus.LOin    = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                if (opClass == CLS_MULDIV) begin
                    bus.Zhighout = 1'b1;
                    bus.HIin     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    reg_select #(.NUM_REGS(NUM_REGS)) u_rinSel (
        .idx_i    (rinIdx),
        .en_i     (rinEn),
        .onehot_o (bus.Rin)
    );

    reg_select #(.NUM_REGS(NUM_REGS)) u_routSel (
        .idx_i    (routIdx),
        .en_i     (routEn),
        .onehot_o (bus.Rout)
    );

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: an instruction table is expanded into
// per-cycle expected output vectors on a scoreboard queue and compared each cycle.
module tb_control_unit;

    typedef struct packed {
        logic        PCout, Zlowout, Zhighout, MDRout, Cout;
        logic        MARin, MDRin, IRin, PCin, Yin, Zin, HIin, LOin;
        logic        IncPC, Read;
        logic [15:0] Rin, Rout;
        logic [4:0]  ALU_Sel;
        logic        Busy, Halted, Err;
    } outs_t;

    typedef struct {
        logic [31:0] ir;
        int          stalls;
        int          latency;
        string       name;
    } vec_t;

    typedef struct {
        outs_t exp;
        int    t1Idx;
        string step;
    } sb_t;

    logic Clock   = 1'b0;
    logic Reset_n = 1'b1;
    int   total   = 0;
    int   bad     = 0;

    vec_t vecs[$];
    sb_t  sbq[$];

    control_unit_if #(.NUM_REGS(16)) bus ();

    control_unit #(.NUM_REGS(16)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clock = ~Clock;

    function automatic outs_t sample();
        outs_t s;
        s.PCout = bus.PCout;     s.Zlowout = bus.Zlowout; s.Zhighout = bus.Zhighout;
        s.MDRout = bus.MDRout;   s.Cout = bus.Cout;       s.MARin = bus.MARin;
        s.MDRin = bus.MDRin;     s.IRin = bus.IRin;       s.PCin = bus.PCin;
        s.Yin = bus.Yin;         s.Zin = bus.Zin;         s.HIin = bus.HIin;
        s.LOin = bus.LOin;       s.IncPC = bus.IncPC;     s.Read = bus.Read;
        s.Rin = bus.Rin;         s.Rout = bus.Rout;       s.ALU_Sel = bus.ALU_Sel;
        s.Busy = bus.Busy;       s.Halted = bus.Halted;   s.Err = bus.Err;
        return s;
    endfunction

    function automatic outs_t busyBase();
        outs_t o;
        o = '0;
        o.ALU_Sel = 5'h03;
        o.Busy    = 1'b1;
        return o;
    endfunction

    function automatic outs_t expT0();
        outs_t o;
        o = busyBase();
        o.PCout = 1'b1; o.MARin = 1'b1; o.IncPC = 1'b1; o.Zin = 1'b1;
        return o;
    endfunction

    function automatic outs_t expT1(input bit first);
        outs_t o;
        o = busyBase();
        o.Read = 1'b1; o.MDRin = 1'b1;
        o.Zlowout = first; o.PCin = first;
        return o;
    endfunction

    function automatic logic [31:0] mkIr(input logic [4:0] op, input logic [3:0] ra,
                                         input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'h0000};
    endfunction

    function automatic void push(input string step, input int t1Idx, input outs_t o);
        sb_t e;
        e.exp = o; e.t1Idx = t1Idx; e.step = step;
        sbq.push_back(e);
    endfunction

    // Expected per-cycle outputs of one instruction, written from the step tables.
    function automatic void pushInstr(input logic [31:0] ir, input int stalls);
        outs_t       o;
        logic [4:0]  op;
        logic [15:0] ra1h, rb1h, rc1h;
        op   = ir[31:27];
        ra1h = 16'h0001 << ir[26:23];
        rb1h = 16'h0001 << ir[22:19];
        rc1h = 16'h0001 << ir[18:15];
        push("T0", -1, expT0());
        for (int k = 0; k <= stalls; k++) push("T1", k, expT1(k == 0));
        o = busyBase(); o.MDRout = 1'b1; o.IRin = 1'b1;
        push("T2", -1, o);
        if (op >= 5'h03 && op <= 5'h0E) begin
            o = busyBase(); o.Rout = rb1h; o.Yin = 1'b1;
            push("T3", -1, o);
            o = busyBase(); o.Zin = 1'b1;
            if (op <= 5'h0B) begin
                o.Rout = rc1h; o.ALU_Sel = op;
            end else begin
                o.Cout = 1'b1;
                o.ALU_Sel = (op == 5'h0C) ? 5'h03 : (op == 5'h0D) ? 5'h09 : 5'h0A;
            end
            push("T4", -1, o);
            o = busyBase(); o.Zlowout = 1'b1; o.Rin = ra1h;
            push("T5", -1, o);
        end else if (op == 5'h0F || op == 5'h10) begin
            o = busyBase(); o.Rout = ra1h; o.Yin = 1'b1;
            push("T3", -1, o);
            o = busyBase(); o.Rout = rb1h; o.Zin = 1'b1; o.ALU_Sel = op;
            push("T4", -1, o);
            o = busyBase(); o.Zlowout = 1'b1; o.LOin = 1'b1;
            push("T5", -1, o);
            o = busyBase(); o.Zhighout = 1'b1; o.HIin = 1'b1;
            push("T6", -1, o);
        end else if (op == 5'h11 || op == 5'h12) begin
            o = busyBase(); o.Rout = rb1h; o.Zin = 1'b1; o.ALU_Sel = op;
            push("T3", -1, o);
            o = busyBase(); o.Zlowout = 1'b1; o.Rin = ra1h;
            push("T4", -1, o);
        end else if (op == 5'h14 || op == 5'h15) begin
            push("T3", -1, busyBase());
        end else begin
            o = busyBase(); o.Err = 1'b1;
            push("T3", -1, o);
        end
    endfunction

    task automatic checkOutput(input string name, input outs_t exp);
        outs_t act;
        act = sample();
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Entered at the falling edge where the DUT sits in T0 of this instruction.
    task automatic applyStimulus(input vec_t v);
        sb_t e;
        int  k;
        int  measured;
        bus.IR = v.ir;
        pushInstr(v.ir, v.stalls);
        k = 0;
        measured = -1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (k > 0 && measured < 0 && (bus.PCout || bus.Halted)) measured = k;
            checkOutput({v.name, ":", e.step}, e.exp);
            bus.Mem_ready = (e.t1Idx < 0) || (e.t1Idx >= v.stalls);
            @(negedge Clock);
            k++;
        end
        if (measured < 0 && (bus.PCout || bus.Halted)) measured = k;
        total++;
        if (measured != v.latency) begin
            bad++;
            $display("[TB] FAIL %s:latency: got %0d want %0d", v.name, measured, v.latency);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        outs_t haltExp;
        haltExp = '0;
        haltExp.ALU_Sel = 5'h03;
        haltExp.Halted  = 1'b1;

        vecs.push_back('{32'h4A920000, 0, 6, "and_r5_r2_r4"});
        vecs.push_back('{32'h4A920000, 3, 9, "and_stall3"});
        vecs.push_back('{32'h60900005, 0, 6, "addi_r1_r2"});
        vecs.push_back('{32'h78800000, 0, 7, "mul_r1_r0"});
        vecs.push_back('{mkIr(5'h04, 4'd3, 4'd7, 4'd8), 0, 6, "sub_r3_r7_r8"});
        vecs.push_back('{mkIr(5'h0E, 4'd15, 4'd9, 4'd0), 0, 6, "ori_r15_r9"});
        vecs.push_back('{mkIr(5'h10, 4'd6, 4'd12, 4'd0), 1, 8, "div_r6_r12"});
        vecs.push_back('{mkIr(5'h11, 4'd0, 4'd14, 4'd0), 0, 5, "neg_r0_r14"});
        vecs.push_back('{mkIr(5'h12, 4'd10, 4'd11, 4'd0), 2, 7, "not_r10_r11"});
        vecs.push_back('{mkIr(5'h14, 4'd1, 4'd2, 4'd3), 0, 4, "nop"});
        vecs.push_back('{32'hF8000000, 0, 4, "illegal_1f"});
        vecs.push_back('{mkIr(5'h13, 4'd4, 4'd5, 4'd6), 0, 4, "illegal_13"});
        vecs.push_back('{32'hA8000000, 0, 4, "halt"});

        bus.Start     = 1'b0;
        bus.IR        = 32'h0;
        bus.Mem_ready = 1'b1;

        #1 Reset_n = 1'b0;
        #2 checkOutput("reset", '0);
        @(negedge Clock);
        Reset_n = 1'b1;
        @(negedge Clock);
        checkOutput("idle_no_start", '0);
        bus.Start = 1'b1;
        @(negedge Clock);
        bus.Start = 1'b0;

        foreach (vecs[i]) applyStimulus(vecs[i]);

        bus.Start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("halt_hold", haltExp);
            @(negedge Clock);
        end
        bus.Start = 1'b0;

        #2 Reset_n = 1'b0;
        #1 checkOutput("reset_from_halt", '0);
        @(negedge Clock);
        Reset_n = 1'b1;
        bus.Start = 1'b1;
        @(negedge Clock);
        bus.Start = 1'b0;
        checkOutput("restart_T0", expT0());
        bus.IR = 32'h4A920000;
        bus.Mem_ready = 1'b0;
        @(negedge Clock);
        checkOutput("stall_T1_first", expT1(1'b1));
        @(negedge Clock);
        checkOutput("stall_T1_wait", expT1(1'b0));
        #2 Reset_n = 1'b0;
        #1 checkOutput("reset_mid_T1", '0);
        @(negedge Clock);
        Reset_n = 1'b1;
        bus.Mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            checkOutput("idle_after_reset", '0);
        end
        bus.Start = 1'b1;
        @(negedge Clock);
        bus.Start = 1'b0;
        checkOutput("T0_after_start", expT0());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
